// File: rtl/ps2_device_tx_if.sv
// Byte handshake plus PS/2 line sense/drive bundle for ps2_device_tx.
// master = host/system side, slave = the transmitter itself.
interface ps2_device_tx_if;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_abort;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;

  modport master (
    output tx_byte, tx_valid, ps2_clk_in, ps2_data_in,
    input  tx_ready, tx_done, tx_abort, ps2_clk_oe, ps2_data_oe
  );

  modport slave (
    input  tx_byte, tx_valid, ps2_clk_in, ps2_data_in,
    output tx_ready, tx_done, tx_abort, ps2_clk_oe, ps2_data_oe
  );
endinterface

// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: 11-bit frames (start, 8 data LSB first, odd parity, stop) on open-drain lines.
// Optional PS2_TX_FIFO_EN adds a 4-entry byte FIFO ahead of the serialiser.
module ps2_device_tx #(
  parameter int HALF_CYC = 2500,
  parameter int GAP_CYC  = 5000
) (
  input logic            clk,
  input logic            reset,
  ps2_device_tx_if.slave bus
);
  localparam int HW = $clog2(HALF_CYC + 1);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [HW-1:0] HALF_LAST   = HW'(HALF_CYC - 1);
  localparam logic [HW-1:0] HALF_MAX    = {HW{1'b1}};
  localparam logic [HW-1:0] SYNC_SETTLE = HW'(2);
  localparam logic [GW-1:0] GAP_LAST    = GW'(GAP_CYC - 1);
  localparam logic [GW-1:0] GAP_MAX     = {GW{1'b1}};
  localparam logic [3:0]    LAST_BIT    = 4'd10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_IDLE = 3'd1,
    SETUP     = 3'd2,
    LOW       = 3'd3,
    GAP       = 3'd4
  } state_t;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  state_t       state_r;
  logic [1:0]   clk_sync_r;
  logic [1:0]   data_sync_r;
  logic [HW-1:0] half_cnt_r;
  logic [GW-1:0] idle_cnt_r;
  logic [3:0]   bit_idx_r;
  logic [10:0]  frame_r;
  logic         clk_oe_r;
  logic         data_oe_r;
  logic         done_r;
  logic         abort_r;
  logic         ready_r;

  logic         clk_s;
  logic         line_idle_s;
  logic         gap_done_s;
  logic [3:0]   next_idx_s;
  logic         start_s;
  logic [7:0]   start_byte_s;

  // Line-sense synchronisers; idle-high after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], bus.ps2_clk_in};
      data_sync_r <= {data_sync_r[0], bus.ps2_data_in};
    end
  end

  // Decoded line state and shared FSM conditions.
  always_comb begin
    clk_s       = clk_sync_r[1];
    line_idle_s = clk_sync_r[1] && data_sync_r[1];
    gap_done_s  = (state_r == GAP) && (idle_cnt_r == GAP_LAST);
    next_idx_s  = bit_idx_r + 4'd1;
  end

`ifdef PS2_TX_FIFO_EN
  logic [7:0] fifo_mem_r [4];
  logic [1:0] wr_ptr_r;
  logic [1:0] rd_ptr_r;
  logic [2:0] fifo_cnt_r;
  logic [2:0] fifo_cnt_next_s;
  logic       push_s;

  // FIFO push/pop decode; the serialiser pops whenever it sits in IDLE.
  always_comb begin
    push_s          = bus.tx_valid && ready_r;
    start_s         = (state_r == IDLE) && (fifo_cnt_r != 3'd0);
    start_byte_s    = fifo_mem_r[rd_ptr_r];
    fifo_cnt_next_s = fifo_cnt_r + {2'b00, push_s} - {2'b00, start_s};
  end

  // FIFO storage, pointers and registered not-full ready.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r   <= 2'd0;
      rd_ptr_r   <= 2'd0;
      fifo_cnt_r <= 3'd0;
      ready_r    <= 1'b1;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= bus.tx_byte;
        wr_ptr_r             <= wr_ptr_r + 2'd1;
      end
      if (start_s) begin
        rd_ptr_r <= rd_ptr_r + 2'd1;
      end
      fifo_cnt_r <= fifo_cnt_next_s;
      ready_r    <= (fifo_cnt_next_s != 3'd4);
    end
  end
`else
  // Single holding register: the byte is taken straight from the bus on accept.
  always_comb begin
    start_s      = (state_r == IDLE) && bus.tx_valid && ready_r;
    start_byte_s = bus.tx_byte;
  end

  // Ready is high exactly while the serialiser is in IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ready_r <= 1'b1;
    end else if (start_s) begin
      ready_r <= 1'b0;
    end else if (gap_done_s) begin
      ready_r <= 1'b1;
    end else begin
      ready_r <= ready_r;
    end
  end
`endif

  // Frame serialiser with host-inhibit abort and retry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= IDLE;
      clk_oe_r   <= 1'b0;
      data_oe_r  <= 1'b0;
      done_r     <= 1'b0;
      abort_r    <= 1'b0;
      half_cnt_r <= {HW{1'b0}};
      idle_cnt_r <= {GW{1'b0}};
      bit_idx_r  <= 4'd0;
      frame_r    <= 11'h000;
    end else begin
      done_r  <= 1'b0;
      abort_r <= 1'b0;
      case (state_r)
        IDLE: begin
          clk_oe_r  <= 1'b0;
          data_oe_r <= 1'b0;
          if (start_s) begin
            frame_r    <= {1'b1, odd_parity(start_byte_s), start_byte_s, 1'b0};
            idle_cnt_r <= {GW{1'b0}};
            state_r    <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (!line_idle_s) begin
            idle_cnt_r <= {GW{1'b0}};
          end else if (idle_cnt_r == GAP_LAST) begin
            bit_idx_r  <= 4'd0;
            half_cnt_r <= {HW{1'b0}};
            data_oe_r  <= ~frame_r[0];
            state_r    <= SETUP;
          end else begin
            idle_cnt_r <= (idle_cnt_r == GAP_MAX) ? idle_cnt_r : idle_cnt_r + GW'(1);
          end
        end
        SETUP: begin
          // Our own clock release needs two cycles to reach the synchroniser output,
          // so a low sensed clock only counts as inhibit after that.
          if (!clk_s && (half_cnt_r >= SYNC_SETTLE)) begin
            clk_oe_r   <= 1'b0;
            data_oe_r  <= 1'b0;
            abort_r    <= 1'b1;
            bit_idx_r  <= 4'd0;
            idle_cnt_r <= {GW{1'b0}};
            state_r    <= WAIT_IDLE;
          end else if (half_cnt_r == HALF_LAST) begin
            clk_oe_r   <= 1'b1;
            half_cnt_r <= {HW{1'b0}};
            state_r    <= LOW;
          end else begin
            half_cnt_r <= (half_cnt_r == HALF_MAX) ? half_cnt_r : half_cnt_r + HW'(1);
          end
        end
        LOW: begin
          if (half_cnt_r == HALF_LAST) begin
            clk_oe_r   <= 1'b0;
            half_cnt_r <= {HW{1'b0}};
            if (bit_idx_r < LAST_BIT) begin
              bit_idx_r <= next_idx_s;
              data_oe_r <= ~frame_r[next_idx_s];
              state_r   <= SETUP;
            end else begin
              data_oe_r  <= 1'b0;
              done_r     <= 1'b1;
              idle_cnt_r <= {GW{1'b0}};
              state_r    <= GAP;
            end
          end else begin
            half_cnt_r <= (half_cnt_r == HALF_MAX) ? half_cnt_r : half_cnt_r + HW'(1);
          end
        end
        GAP: begin
          clk_oe_r  <= 1'b0;
          data_oe_r <= 1'b0;
          if (gap_done_s) begin
            state_r <= IDLE;
          end else begin
            idle_cnt_r <= (idle_cnt_r == GAP_MAX) ? idle_cnt_r : idle_cnt_r + GW'(1);
          end
        end
        default: begin
          clk_oe_r  <= 1'b0;
          data_oe_r <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx_ready    = ready_r;
  assign bus.tx_done     = done_r;
  assign bus.tx_abort    = abort_r;
  assign bus.ps2_clk_oe  = clk_oe_r;
  assign bus.ps2_data_oe = data_oe_r;
endmodule

// File: tb/tb_ps2_device_tx.sv
// Directed + random bench for ps2_device_tx with an open-drain line model and a host receiver model.
module tb_ps2_device_tx;
  localparam int HALF      = 4;
  localparam int GAP       = 8;
  localparam int FRAME_CYC = 22 * HALF;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic host_clk_hold = 1'b0;
  logic host_data_hold = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  ps2_device_tx_if bus();

  logic clk_line;
  logic data_line;
  assign clk_line        = ~bus.ps2_clk_oe & ~host_clk_hold;
  assign data_line       = ~bus.ps2_data_oe & ~host_data_hold;
  assign bus.ps2_clk_in  = clk_line;
  assign bus.ps2_data_in = data_line;

  ps2_device_tx #(.HALF_CYC(HALF), .GAP_CYC(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Host receiver model: sample data on each device-driven falling clock edge.
  logic [10:0] rx_bits = 11'h000;
  logic [10:0] last_frame = 11'h000;
  logic [7:0]  rx_q[$];
  int          nbits = 0;
  int          rx_err = 0;
  int          done_cnt = 0;
  int          abort_cnt = 0;
  logic        prev_clk_line = 1'b1;

  initial begin
    forever begin
      @(negedge clk);
      if (bus.tx_done === 1'b1 || bus.tx_abort === 1'b1) begin
        checks++;
        assert (!(bus.tx_done === 1'b1 && bus.tx_abort === 1'b1)) else begin
          errors++;
          $error("FAIL done_abort_overlap observed done=%0b abort=%0b expected not both", bus.tx_done, bus.tx_abort);
        end
      end
      if (bus.tx_done === 1'b1) done_cnt++;
      if (bus.tx_abort === 1'b1) abort_cnt++;
      if (!reset || host_clk_hold) begin
        nbits = 0;
      end else if (prev_clk_line && !clk_line) begin
        rx_bits = {data_line, rx_bits[10:1]};
        nbits++;
        if (nbits == 11) begin
          last_frame = rx_bits;
          rx_q.push_back(rx_bits[8:1]);
          if (rx_bits[0] !== 1'b0 || rx_bits[10] !== 1'b1 || (^rx_bits[9:1]) !== 1'b1) rx_err++;
          nbits = 0;
        end
      end
      prev_clk_line = clk_line;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  function automatic logic [8:0] rx_pop();
    if (rx_q.size() == 0) return 9'h100;
    return {1'b0, rx_q.pop_front()};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    while (bus.tx_ready !== 1'b1 && n < 500) begin
      tick();
      n++;
    end
    check("send_ready", 32'(bus.tx_ready), 32'd1);
    bus.tx_byte  = b;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_start(output int t);
    t = -1;
    for (int n = 0; n < 400; n++) begin
      tick();
      if (bus.ps2_data_oe === 1'b1) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check("start_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(output int t);
    t = -1;
    for (int n = 0; n < 400; n++) begin
      tick();
      if (bus.tx_done === 1'b1) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic find_setup(input int bit_no);
    int n;
    n = 0;
    while (!(nbits == bit_no && bus.ps2_clk_oe === 1'b0) && n < 500) begin
      tick();
      n++;
    end
    check("find_setup_bit", 32'(nbits), 32'(bit_no));
  endtask

  initial begin
    int t0, t1, r, d0, a0;
    logic [7:0] b;
    logic bad;
    bus.tx_byte  = 8'h00;
    bus.tx_valid = 1'b0;

    repeat (3) tick();
    check("rst_ready", 32'(bus.tx_ready), 32'd1);
    check("rst_oe", 32'({bus.ps2_clk_oe, bus.ps2_data_oe}), 32'd0);
    check("rst_pulses", 32'({bus.tx_done, bus.tx_abort}), 32'd0);
    reset = 1'b1;
    tick();

    // 0x08: exact bit sequence, frame latency, release and gap
    send(8'h08);
    wait_start(t0);
    wait_done(t1);
    check("f08_latency", 32'(t1 - t0), 32'(FRAME_CYC));
    check("f08_bits", 32'(last_frame), 32'h410);
    check("f08_released", 32'({bus.ps2_clk_oe, bus.ps2_data_oe}), 32'd0);
    check("f08_rx", 32'(rx_pop()), 32'h008);
`ifndef PS2_TX_FIFO_EN
    repeat (GAP - 1) tick();
    check("gap_ready_low", 32'(bus.tx_ready), 32'd0);
    tick();
    check("gap_ready_high", 32'(bus.tx_ready), 32'd1);
`else
    repeat (GAP) tick();
`endif

    // 0x00: parity and stop bits both 1
    send(8'h00);
    wait_start(t0);
    wait_done(t1);
    check("f00_bits", 32'(last_frame), 32'h600);
    check("f00_rx", 32'(rx_pop()), 32'h000);
    check("f00_rx_err", 32'(rx_err), 32'd0);

    // 0xAA: host inhibit in SETUP of bit 5, then full retry
    d0 = done_cnt;
    a0 = abort_cnt;
    send(8'hAA);
    find_setup(5);
    host_clk_hold = 1'b1;
    repeat (20) tick();
    check("aa_abort_once", 32'(abort_cnt - a0), 32'd1);
    check("aa_released", 32'({bus.ps2_clk_oe, bus.ps2_data_oe}), 32'd0);
    host_clk_hold = 1'b0;
    r = cyc;
    wait_start(t0);
    check("aa_retry_delay", 32'((t0 - r >= GAP) && (t0 - r <= GAP + 3)), 32'd1);
    wait_done(t1);
    check("aa_latency", 32'(t1 - t0), 32'(FRAME_CYC));
    repeat (GAP + 2) tick();
    check("aa_rx", 32'(rx_pop()), 32'h0AA);
    check("aa_rx_once", 32'(rx_q.size()), 32'd0);
    check("aa_done_once", 32'(done_cnt - d0), 32'd1);
    check("aa_abort_total", 32'(abort_cnt - a0), 32'd1);

    // 0x55 with host request-to-send holding data low
    host_data_hold = 1'b1;
    send(8'h55);
    bad = 1'b0;
    repeat (40) begin
      tick();
      if (bus.ps2_data_oe !== 1'b0 || bus.ps2_clk_oe !== 1'b0) bad = 1'b1;
    end
    check("rts_no_frame", 32'(bad), 32'd0);
    host_data_hold = 1'b0;
    r = cyc;
    wait_start(t0);
    check("rts_start_delay", 32'((t0 - r >= GAP) && (t0 - r <= GAP + 3)), 32'd1);
    wait_done(t1);
    check("rts_rx", 32'(rx_pop()), 32'h055);

    // reset during bit 3 of 0xF0
    repeat (GAP + 2) tick();
    d0 = done_cnt;
    a0 = abort_cnt;
    send(8'hF0);
    find_setup(3);
    reset = 1'b0;
    tick();
    check("mid_rst_oe", 32'({bus.ps2_clk_oe, bus.ps2_data_oe}), 32'd0);
    check("mid_rst_ready", 32'(bus.tx_ready), 32'd1);
    check("mid_rst_pulses", 32'({bus.tx_done, bus.tx_abort}), 32'd0);
    tick();
    reset = 1'b1;
    repeat (40) tick();
    check("mid_rst_no_rx", 32'(rx_q.size()), 32'd0);
    check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    check("mid_rst_no_abort", 32'(abort_cnt - a0), 32'd0);

    // random bytes against the frame model
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      send(b);
      wait_start(t0);
`ifndef PS2_TX_FIFO_EN
      bus.tx_byte  = ~b;
      bus.tx_valid = 1'b1;
      tick();
      check("busy_ready_low", 32'(bus.tx_ready), 32'd0);
      tick();
      bus.tx_valid = 1'b0;
`endif
      wait_done(t1);
      check("rand_latency", 32'(t1 - t0), 32'(FRAME_CYC));
      check("rand_bits", 32'(last_frame), 32'(frame_of(b)));
      check("rand_rx", 32'(rx_pop()), 32'({1'b0, b}));
    end
    repeat (3 * GAP + 40) tick();
    check("rand_no_extra_rx", 32'(rx_q.size()), 32'd0);

`ifdef PS2_TX_FIFO_EN
    // FIFO: fill behind a busy serialiser, blocked push, in-order delivery with gaps
    send(8'hFA);
    wait_start(t0);
    for (int i = 0; i < 4; i++) begin
      bus.tx_byte  = 8'(8'h08 >> (i == 0 ? 0 : 3)) + 8'(i == 0 ? 0 : i - 1 + (i == 1 ? 0 : 0));
      bus.tx_byte  = (i == 0) ? 8'h08 : 8'(i);
      bus.tx_valid = 1'b1;
      tick();
    end
    bus.tx_valid = 1'b0;
    check("fifo_full_ready", 32'(bus.tx_ready), 32'd0);
    bus.tx_byte  = 8'h04;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_done(t1);
      if (k < 4) begin
        wait_start(t0);
        check("fifo_gap", 32'(t0 - t1 >= GAP), 32'd1);
      end
    end
    repeat (3 * GAP) tick();
    check("fifo_rx0", 32'(rx_pop()), 32'h0FA);
    check("fifo_rx1", 32'(rx_pop()), 32'h008);
    check("fifo_rx2", 32'(rx_pop()), 32'h001);
    check("fifo_rx3", 32'(rx_pop()), 32'h002);
    check("fifo_rx4", 32'(rx_pop()), 32'h003);
    check("fifo_blocked", 32'(rx_q.size()), 32'd0);
`endif

    check("rx_frame_errors", 32'(rx_err), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
